// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus: scanout read port, writer port and the shared RAM port.
// master = clients + RAM side, slave = arbiter.
interface vga_fb_arbiter_if #(
  parameter int AW = 21,
  parameter int DW = 8
);
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Double-buffered frame-buffer arbiter: scanout reads have strict priority over the
// image writer; display/write banks swap at vblank once the writer finishes a frame.
module vga_fb_arbiter #(
  parameter int AW     = 21,
  parameter int DW     = 8,
  parameter int RD_LAT = 2   // 1..4
) (
  input  logic             clk_pixel,
  input  logic             rst,
  vga_fb_arbiter_if.slave  bus,
  input  logic             frame_done,
  input  logic             vblank_start,
  output logic             disp_bank,
  output logic             wr_bank,
  output logic             swap_pending
);

  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW:0]   addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  typedef enum logic {SW_IDLE, SW_PEND} sw_state_t;

  sw_state_t     sw_q, sw_d;
  logic          bank_q, bank_d;
  mem_req_t      req_q, req_d;
  logic [RD_LAT:0] vld_pipe;   // bit 0 is the registered grant, bit RD_LAT aligns with mem_rdata
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          wr_ready;

  assign wr_ready = !rst && !bus.disp_req && (sw_q == SW_IDLE);

  // Bank bit is folded into the address here, so a later swap cannot redirect it.
  always_comb begin
    req_d    = req_q;
    req_d.en = 1'b0;
    req_d.we = 1'b0;
    if (bus.disp_req) begin
      req_d.en   = 1'b1;
      req_d.addr = {bank_q, bus.disp_addr};
    end else if (bus.wr_valid && wr_ready) begin
      req_d.en    = 1'b1;
      req_d.we    = 1'b1;
      req_d.addr  = {!bank_q, bus.wr_addr};
      req_d.wdata = bus.wr_data;
    end
  end

  always_comb begin
    sw_d   = sw_q;
    bank_d = bank_q;
    case (sw_q)
      SW_IDLE: if (frame_done) begin
        if (vblank_start) bank_d = !bank_q;
        else              sw_d   = SW_PEND;
      end
      SW_PEND: if (vblank_start) begin
        bank_d = !bank_q;
        sw_d   = SW_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      sw_q     <= SW_IDLE;
      bank_q   <= 1'b0;
      req_q    <= '0;
      vld_pipe <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sw_q     <= sw_d;
      bank_q   <= bank_d;
      req_q    <= req_d;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], req_d.en && !req_d.we};
      rvalid_q <= vld_pipe[RD_LAT];
      if (vld_pipe[RD_LAT]) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.disp_gnt    = vld_pipe[0];
  assign bus.disp_rvalid = rvalid_q;
  assign bus.disp_rdata  = rdata_q;
  assign bus.mem_en      = req_q.en;
  assign bus.mem_we      = req_q.we;
  assign bus.mem_addr    = req_q.addr;
  assign bus.mem_wdata   = req_q.wdata;
  assign disp_bank       = bank_q;
  assign wr_bank         = !bank_q;
  assign swap_pending    = (sw_q == SW_PEND);

endmodule
